// File: rtl/jtdd_arb_pkg.sv
// Shared constants, FSM encoding and the round-robin picker for the SDRAM slot arbiter.
package jtdd_arb_pkg;
    localparam int NSLOT = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;
    localparam int LW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Returns {found, index}. The scan starts at the slot after `last`, so the
    // slot that was just served is considered last.
    function automatic logic [2:0] rr_pick(input logic [NSLOT-1:0] pend, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] r;
        r = {1'b0, last};
        for (int k = 1; k <= NSLOT; k++) begin
            idx = last + 2'(k);
            if (!r[2] && pend[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction
endpackage

// File: rtl/jtdd_arb_line.sv
// One-line read cache for a single slot: 32-bit line, word-pair tag, valid bit and hit/mux.
module jtdd_arb_line
    import jtdd_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr,
    input  logic [LW-1:0] wr_data,
    input  logic [AW-2:0] wr_tag,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          block,
    output logic [DW-1:0] dout,
    output logic          ok,
    output logic          hit
);
    logic [LW-1:0] line;
    logic [AW-2:0] tag;
    logic          valid;
    logic [DW-1:0] dout_q, word;

    assign hit  = valid && (tag == addr[AW-1:1]);
    assign ok   = cs && hit && !block;
    assign word = addr[0] ? line[31:16] : line[15:0];
    // Hits forward the word immediately; otherwise the last delivered word stays put.
    assign dout = ok ? word : dout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line   <= '0;
            tag    <= '0;
            valid  <= 1'b0;
            dout_q <= '0;
        end else begin
            if (wr) begin
                line <= wr_data;
                tag  <= wr_tag;
            end
            if (flush)   valid <= 1'b0;
            else if (wr) valid <= 1'b1;
            if (ok) dout_q <= word;
        end
    end
endmodule

// File: rtl/jtdd_sdram_arb.sv
// Four-slot SDRAM read arbiter: per-slot line caches, round-robin grant, one burst in flight.
module jtdd_sdram_arb
    import jtdd_arb_pkg::*;
#(
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       downloading,
    input  logic                       loop_rst,
    input  logic [NSLOT-1:0]           slot_cs,
    input  logic [NSLOT-1:0][AW-1:0]   slot_addr,
    output logic [NSLOT-1:0][DW-1:0]   slot_dout,
    output logic [NSLOT-1:0]           slot_ok,
    output logic                       sdram_req,
    output logic [AW-1:0]              sdram_addr,
    input  logic                       sdram_ack,
    input  logic                       data_rdy,
    input  logic [LW-1:0]              data_read,
    output logic                       refresh_en
);
    localparam logic [NSLOT-1:0][AW-1:0] OFFS = {SLOT3_OFFSET, SLOT2_OFFSET, SLOT1_OFFSET, SLOT0_OFFSET};

    arb_state_t       state, nxt;
    logic [NSLOT-1:0] hit, pending;
    logic [1:0]       last, gnt, sel;
    logic [2:0]       pick;
    logic             sel_vld, grant, fill, flush, discard;
    logic [AW-2:0]    gnt_tag;

    assign pending = slot_cs & ~hit;
    assign pick    = rr_pick(pending, last);
    assign sel_vld = pick[2];
    assign sel     = pick[1:0];

    always_comb begin
        nxt   = state;
        grant = 1'b0;
        if (downloading) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (sel_vld) begin
                    nxt   = ST_REQ;
                    grant = 1'b1;
                end
                ST_REQ:  if (sdram_ack) nxt = ST_WAIT;
                ST_WAIT: if (data_rdy)  nxt = ST_IDLE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    // A flush seen while waiting poisons the burst still on its way back.
    assign fill       = (state == ST_WAIT) && data_rdy && !discard && !loop_rst && !downloading;
    assign flush      = loop_rst || downloading;
    assign sdram_req  = (state == ST_REQ) && !downloading;
    assign refresh_en = (state == ST_IDLE) && !(|pending) && !downloading;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last       <= 2'd3;
            gnt        <= 2'd0;
            gnt_tag    <= '0;
            sdram_addr <= '0;
            discard    <= 1'b0;
        end else begin
            state <= nxt;
            if (grant) begin
                gnt        <= sel;
                last       <= sel;
                gnt_tag    <= slot_addr[sel][AW-1:1];
                sdram_addr <= {slot_addr[sel][AW-1:1], 1'b0} + OFFS[sel];
            end
            if (state == ST_WAIT && loop_rst && nxt == ST_WAIT) discard <= 1'b1;
            else if (nxt != ST_WAIT)                             discard <= 1'b0;
        end
    end

    for (genvar i = 0; i < NSLOT; i++) begin : g_line
        jtdd_arb_line u_line (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .wr      (fill && gnt == 2'(i)),
            .wr_data (data_read),
            .wr_tag  (gnt_tag),
            .cs      (slot_cs[i]),
            .addr    (slot_addr[i]),
            .block   (downloading),
            .dout    (slot_dout[i]),
            .ok      (slot_ok[i]),
            .hit     (hit[i])
        );
    end
endmodule

// File: tb/tb_jtdd_sdram_arb.sv
// Directed bench for jtdd_sdram_arb: hit/miss, round-robin, flush, download and reset cases.
module tb_jtdd_sdram_arb;
    logic              clk = 1'b0;
    logic              rst;
    logic              downloading, loop_rst;
    logic [3:0]        slot_cs;
    logic [3:0][21:0]  slot_addr;
    logic [3:0][15:0]  slot_dout;
    logic [3:0]        slot_ok;
    logic              sdram_req;
    logic [21:0]       sdram_addr;
    logic              sdram_ack, data_rdy;
    logic [31:0]       data_read;
    logic              refresh_en;

    int errors = 0;
    int checks = 0;

    jtdd_sdram_arb #(
        .SLOT0_OFFSET (22'h28000),
        .SLOT1_OFFSET (22'h01000),
        .SLOT2_OFFSET (22'h02000),
        .SLOT3_OFFSET (22'h3FFFF0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_dout   (slot_dout),
        .slot_ok     (slot_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [21:0] exp_addr);
        int n = 0;
        #1;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(sdram_req), 32'd1);
        chk({tag, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
    endtask

    task automatic do_ack();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        #1;
        chk("req_drop", 32'(sdram_req), 32'd0);
    endtask

    task automatic do_fill(input logic [31:0] d);
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        slot_cs = '0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        tick(); tick();
        chk("rst_req",  32'(sdram_req),  32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_ok",   32'(slot_ok),    32'd0);
        chk("rst_dout", slot_dout[0] == 16'h0 && slot_dout[3] == 16'h0, 32'd1);
        rst = 1'b1;
        tick();
        chk("idle_refresh", 32'(refresh_en), 32'd1);

        // Single miss on slot 0 with offset applied, then hit on both halves.
        slot_cs = 4'b0001; slot_addr[0] = 22'h0010;
        #1;
        chk("miss_ok", 32'(slot_ok[0]), 32'd0);
        chk("miss_refresh", 32'(refresh_en), 32'd0);
        wait_req("s0", 22'h28010);
        do_ack();
        do_fill(32'hBEEF_1234);
        chk("hit_ok",   32'(slot_ok[0]),   32'd1);
        chk("hit_dout", 32'(slot_dout[0]), 32'h1234);
        slot_addr[0] = 22'h0011;
        #1;
        chk("hi_ok",   32'(slot_ok[0]),   32'd1);
        chk("hi_dout", 32'(slot_dout[0]), 32'hBEEF);
        tick();
        chk("hi_noreq",  32'(sdram_req),  32'd0);
        chk("hi_refresh", 32'(refresh_en), 32'd1);

        // Round-robin from a fresh reset, slot 0 re-missing after its fill.
        rst = 1'b0; tick(); rst = 1'b1;
        slot_cs = 4'b1111;
        slot_addr[0] = 22'h20; slot_addr[1] = 22'h41; slot_addr[2] = 22'h60; slot_addr[3] = 22'h80;
        wait_req("rr0", 22'h28020); do_ack(); do_fill(32'hC0D0_5000);
        chk("rr0_dout", 32'(slot_dout[0]), 32'h5000);
        slot_addr[0] = 22'h30;
        wait_req("rr1", 22'h01040); do_ack(); do_fill(32'hC0D1_5001);
        wait_req("rr2", 22'h02060); do_ack(); do_fill(32'hC0D2_5002);
        wait_req("rr3", 22'h00070); do_ack(); do_fill(32'hC0D3_5003);
        wait_req("rr0b", 22'h28030); do_ack(); do_fill(32'hC0D4_5004);
        chk("rr_allok", 32'(slot_ok), 32'hF);
        chk("rr_dout0", 32'(slot_dout[0]), 32'h5004);
        chk("rr_dout1", 32'(slot_dout[1]), 32'hC0D1);
        chk("rr_dout3", 32'(slot_dout[3]), 32'h5003);
        chk("rr_refresh", 32'(refresh_en), 32'd1);

        // Flush while waiting: returning data is dropped, slot re-requested.
        slot_cs = 4'b0100; slot_addr[2] = 22'h100;
        wait_req("lr", 22'h02100); do_ack();
        loop_rst = 1'b1; tick(); loop_rst = 1'b0;
        do_fill(32'hDEAD_0000);
        chk("lr_ok", 32'(slot_ok), 32'd0);
        chk("lr_idle", 32'(sdram_req), 32'd0);
        tick();
        chk("lr_rereq", 32'(sdram_req), 32'd1);
        chk("lr_readdr", 32'(sdram_addr), 32'h02100);
        do_ack(); do_fill(32'h7777_6666);
        chk("lr_fill", 32'(slot_ok[2]), 32'd1);
        chk("lr_dout", 32'(slot_dout[2]), 32'h6666);

        // Download mid-request: request withdrawn, cache invalidated.
        slot_cs = 4'b0101; slot_addr[0] = 22'h200;
        wait_req("dl", 22'h28200);
        chk("dl_prehit", 32'(slot_ok[2]), 32'd1);
        downloading = 1'b1;
        tick();
        chk("dl_req", 32'(sdram_req), 32'd0);
        chk("dl_ok", 32'(slot_ok), 32'd0);
        chk("dl_refresh", 32'(refresh_en), 32'd0);
        tick();
        downloading = 1'b0;
        #1;
        chk("dl_remiss", 32'(slot_ok[2]), 32'd0);
        wait_req("dl2", 22'h02100); do_ack(); do_fill(32'h1111_2222);
        wait_req("dl0", 22'h28200); do_ack(); do_fill(32'h3333_4444);
        chk("dl_allok", 32'(slot_ok), 32'h5);

        // Reset during WAIT, then a stray data_rdy.
        slot_cs = 4'b0001; slot_addr[0] = 22'h300;
        wait_req("rw", 22'h28300); do_ack();
        rst = 1'b0;
        tick();
        chk("rw_req", 32'(sdram_req), 32'd0);
        chk("rw_ok", 32'(slot_ok), 32'd0);
        chk("rw_dout", 32'(slot_dout[0]), 32'd0);
        rst = 1'b1;
        do_fill(32'hBAD0_BAD0);
        chk("rw_stray", 32'(slot_ok[0]), 32'd0);
        chk("rw_rereq", 32'(sdram_req), 32'd1);
        chk("rw_addr", 32'(sdram_addr), 32'h28300);
        do_ack(); do_fill(32'h5555_AAAA);
        chk("rw_fill", 32'(slot_dout[0]), 32'hAAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtdd_sdram_arb.md
JTDD_SDRAM_ARB -- requirements
Module: jtdd_sdram_arb

Interface
REQ-001 SHALL have parameters: SLOT0_OFFSET..SLOT3_OFFSET, default 22'h0, meaning per-slot SDRAM word offset added to the slot address.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-low
- downloading  in  1  ROM download in progress
- loop_rst  in  1  cache flush request
- slot_cs  in  4  per-slot read request
- slot_addr  in  4x22  per-slot 16-bit-word address, packed with slot 0 in [21:0]
- slot_dout  out  4x16  per-slot read data, packed
- slot_ok  out  4  per-slot data valid
- sdram_req  out  1  SDRAM read request
- sdram_addr  out  22  SDRAM word address
- sdram_ack  in  1  request accepted
- data_rdy  in  1  data_read valid
- data_read  in  32  SDRAM burst data, two 16-bit words
- refresh_en  out  1  SDRAM idle, refresh allowed
REQ-003 SHALL use one clock, with reset synchronous and active-low (rst=0 resets on a clk edge).

Function
REQ-004 SHALL keep, per slot, a one-line cache: 32-bit data, 21-bit tag equal to addr[21:1], and a valid bit.
REQ-005 SHALL drive slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==slot_addr[i][21:1]); this is combinational and has 0-cycle latency on a hit.
REQ-006 SHALL drive slot_dout[i] = line[i][15:0] when slot_addr[i][0]=0, and line[i][31:16] otherwise; the value is held while not ok.
REQ-007 SHALL treat slot i as pending when slot_cs[i] & ~hit[i].
REQ-008 SHALL implement FSM states IDLE, REQ and WAIT:
- IDLE -> REQ when any slot is pending.
- REQ -> WAIT on sdram_ack.
- WAIT -> IDLE on data_rdy.
REQ-009 In IDLE, SHALL grant round-robin, scanning from the slot after the last granted slot; the last-granted pointer resets to 3, so slot 0 wins first.
REQ-010 On grant, SHALL latch the slot index and sdram_addr = {slot_addr[21:1],1'b0} + SLOTn_OFFSET, computed modulo 2^22.
REQ-011 SHALL hold sdram_req=1 throughout REQ, and drop it in the same cycle sdram_ack is sampled high.
REQ-012 On data_rdy in WAIT, SHALL write data_read into the granted line, set tag to the latched addr[21:1], and set valid=1.
REQ-013 SHALL ignore data_rdy outside WAIT, and ignore sdram_ack outside REQ.
REQ-014 If the slot address changes or cs drops while a request is in flight, SHALL still complete the fill with the latched tag; ok follows REQ-005.
REQ-015 SHALL drive refresh_en=1 only when in IDLE with no slot pending.
REQ-016 While downloading=1: SHALL clear all valid bits, force IDLE, and hold sdram_req=0, slot_ok=0 and refresh_en=0.
REQ-017 On loop_rst=1, SHALL clear all valid bits; if in WAIT, SHALL discard the returning data (no valid set), then go to IDLE.
REQ-018 When a grant decision and a fill occur in the same cycle, the fill SHALL complete first; re-arbitration happens the next cycle in IDLE.
REQ-019 Worst-case service latency for a slot SHALL be bounded by 4 complete SDRAM transactions.

Reset
REQ-020 On rst=0, SHALL reset: state=IDLE, valid=0 for all slots, sdram_req=0, sdram_addr=0, lines=0, tags=0, last-granted pointer=3, slot_ok=0, slot_dout=0.
REQ-021 SHALL abandon an in-flight transaction on reset, without waiting for data_rdy.

Structure
REQ-022 The FSM state encoding and NSLOT=4 SHALL live in a shared package, jtdd_arb_pkg.
REQ-023 The per-slot line, tag and valid storage plus the hit/mux logic SHALL be one sub-module, jtdd_arb_line, instantiated 4 times.

Verification
REQ-024 Reset then slot_cs=4'b0001, addr0=22'h0010, SLOT0_OFFSET=22'h28000:
- sdram_req=1 and sdram_addr=22'h28010.
- After ack and data_rdy with data_read=32'hBEEF_1234: slot_dout0=16'h1234 and slot_ok[0]=1.
REQ-025 After the REQ-024 fill, change addr0 to 22'h0011: slot_ok[0]=1 in the same cycle with slot_dout0=16'hBEEF, and no sdram_req.
REQ-026 All four slots miss simultaneously: grants SHALL go 0,1,2,3. With slot 0 re-missing after its fill, the next grant order SHALL be 1,2,3 before 0.
REQ-027 loop_rst pulsed during WAIT, then data_rdy: valid stays 0, state returns to IDLE, and the slot is re-requested the next cycle.
REQ-028 downloading=1 mid-REQ: sdram_req drops the next cycle and slot_ok=0. After downloading=0, previously hit addresses miss and are re-fetched.
REQ-029 rst=0 asserted during WAIT: the next cycle has sdram_req=0, state=IDLE and all slot_ok=0. A stray data_rdy after that is ignored.
